// File: rtl/dmem_responder.sv
// Data-memory responder: byte-maskable word RAM with 1-cycle registered reads,
// plus a small MMIO block (console TX FIFO, 64-bit cycle counter, sticky error).
module dmem_responder #(
  parameter int          RAM_WORDS  = 256,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_dmem_addr,
  input  logic        i_dmem_ren,
  input  logic        i_dmem_wen,
  input  logic [31:0] i_dmem_wdata,
  input  logic [3:0]  i_dmem_mask,
  output logic [31:0] o_dmem_rdata,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready,
  output logic        o_err
);
  localparam int          IDX_W     = $clog2(RAM_WORDS);
  localparam int          PTR_W     = $clog2(FIFO_DEPTH);
  localparam int          CNT_W     = PTR_W + 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

  logic [3:0][7:0] ram_q  [RAM_WORDS];
  logic [7:0]      fifo_q [FIFO_DEPTH];

  logic [31:0]      rdata_q, rdata_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      cyc_q, cyc_d;
  logic [31:0]      snap_q, snap_d;
  logic             err_q, err_d;

  logic [31:0]      word_addr;
  logic [IDX_W-1:0] ram_idx;
  logic [1:0]       mmio_off;
  logic             ram_hit, mmio_hit, both, rd_ok;
  logic             fifo_full, fifo_empty, pop, push_req, push, ovf;
  logic             ram_we;
  logic [31:0]      txstat;
  logic             unused_addr_lsbs;

  assign unused_addr_lsbs = ^i_dmem_addr[1:0];

  assign word_addr = {i_dmem_addr[31:2], 2'b00};
  assign ram_idx   = word_addr[IDX_W+1:2];
  assign mmio_off  = word_addr[3:2];
  assign ram_hit   = word_addr < RAM_BYTES;
  assign mmio_hit  = word_addr[31:4] == MMIO_BASE[31:4];
  assign both      = i_dmem_ren & i_dmem_wen;
  // A simultaneous read+write still performs the write but yields no read data.
  assign rd_ok     = i_dmem_ren & ~i_dmem_wen;

  assign fifo_full  = cnt_q == CNT_W'(FIFO_DEPTH);
  assign fifo_empty = cnt_q == '0;
  assign pop        = ~fifo_empty & i_tx_ready;
  assign push_req   = i_dmem_wen & mmio_hit & (mmio_off == 2'd0) & i_dmem_mask[0];
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push       = push_req & (~fifo_full | pop);
  assign ovf        = push_req & fifo_full & ~pop;
  assign ram_we     = i_dmem_wen & ram_hit;

  assign txstat = {17'b0, 7'(cnt_q), 6'b0, fifo_empty, fifo_full};

  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    cyc_d    = cyc_q + 64'd1;
    snap_d   = snap_q;
    if (rd_ok && mmio_hit && mmio_off == 2'd2) snap_d = cyc_q[63:32];
    err_d = err_q | both | ovf
          | ((i_dmem_ren | i_dmem_wen) & ~ram_hit & ~mmio_hit);
  end

  always_comb begin
    rdata_d = '0;
    if (rd_ok) begin
      if (ram_hit) rdata_d = ram_q[ram_idx];
      else if (mmio_hit) begin
        case (mmio_off)
          2'd1:    rdata_d = txstat;
          2'd2:    rdata_d = cyc_q[31:0];
          2'd3:    rdata_d = snap_q;
          default: rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rdata_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      cyc_q    <= '0;
      snap_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      cyc_q    <= cyc_d;
      snap_q   <= snap_d;
      err_q    <= err_d;
    end
  end

  // Storage is not reset; requests in a reset cycle are dropped.
  always_ff @(posedge i_clk) begin
    if (!i_rst && ram_we) begin
      for (int k = 0; k < 4; k++)
        if (i_dmem_mask[k]) ram_q[ram_idx][k] <= i_dmem_wdata[8*k +: 8];
    end
    if (!i_rst && push) fifo_q[wr_ptr_q] <= i_dmem_wdata[7:0];
  end

  assign o_dmem_rdata = rdata_q;
  assign o_tx_valid   = ~fifo_empty;
  assign o_tx_data    = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];
  assign o_err        = err_q;
endmodule
